// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit, type-field and FSM definitions for the router output port
package noc_pkg;

    localparam int FLIT_W_DEF = 34;
    localparam int TYPE_W     = 2;

    typedef enum logic [1:0] {
        FT_BODY      = 2'b00,
        FT_HEAD      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    function automatic logic is_head(input flit_type_t t);
        return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/noc_out_reg.sv
// rtl/noc_out_reg.sv - one-entry valid/ready output register with can-accept indication
module noc_out_reg #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_acc
);

    // A new flit may load whenever the current one is leaving this cycle.
    assign can_acc = !out_valid || out_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= din;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wormhole_output_ctrl.sv
// rtl/wormhole_output_ctrl.sv - output port controller locking the link to one channel per wormhole packet
module wormhole_output_ctrl
    import noc_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [1:0]          in_valid_i,
    input  logic [2*FLIT_W-1:0] in_flit_i,
    output logic [1:0]          in_ready_o,
    output logic [1:0]          req_o,
    input  logic [1:0]          grant_i,
    output logic                out_valid_o,
    output logic [FLIT_W-1:0]   out_flit_o,
    input  logic                out_ready_i,
    output logic                locked_o,
    output logic                owner_o,
    output logic [CNT_W-1:0]    pkt_cnt_o,
    output logic                err_o
);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             can_acc, sel, xfer, cnt_inc, err_set;
    logic [1:0]       head_w;
    logic [FLIT_W-1:0] sel_flit;
    flit_type_t       sel_type;

    assign head_w = {is_head(flit_type_t'(in_flit_i[2*FLIT_W-1 -: TYPE_W])),
                     is_head(flit_type_t'(in_flit_i[FLIT_W-1 -: TYPE_W]))};

    // While locked the owner drives the mux; in IDLE the granted channel does.
    assign sel      = (state_q == ST_LOCK) ? owner_q : grant_i[1];
    assign sel_flit = sel ? in_flit_i[2*FLIT_W-1 -: FLIT_W] : in_flit_i[FLIT_W-1:0];
    assign sel_type = flit_type_t'(sel_flit[FLIT_W-1 -: TYPE_W]);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_o      = 2'b00;
        in_ready_o = 2'b00;
        xfer       = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_o = in_valid_i & head_w;
                if ((grant_i == 2'b11) || ((grant_i & ~req_o) != 2'b00)) begin
                    err_set = 1'b1;
                end else if ((grant_i != 2'b00) && can_acc) begin
                    in_ready_o = grant_i;
                    xfer       = 1'b1;
                    if (sel_type == FT_HEAD) begin
                        state_d = ST_LOCK;
                        owner_d = sel;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                in_ready_o[owner_q] = can_acc;
                xfer                = can_acc && in_valid_i[owner_q];
                if (xfer) begin
                    if (sel_type == FT_TAIL) begin
                        state_d = ST_IDLE;
                        cnt_inc = 1'b1;
                    end else if (is_head(sel_type)) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
            if (err_set) err_q <= 1'b1;
        end
    end

    noc_out_reg #(.W(FLIT_W)) u_out_reg (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (xfer),
        .din       (sel_flit),
        .out_ready (out_ready_i),
        .out_valid (out_valid_o),
        .out_data  (out_flit_o),
        .can_acc   (can_acc)
    );

    assign locked_o  = (state_q == ST_LOCK);
    assign owner_o   = owner_q;
    assign pkt_cnt_o = cnt_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wormhole_output_ctrl.sv
// tb/tb_wormhole_output_ctrl.sv - table-driven bench for wormhole_output_ctrl
module tb_wormhole_output_ctrl;

    localparam int FW = 34;
    localparam logic [1:0] TB_ = 2'b00, TH = 2'b01, TT = 2'b10, THT = 2'b11;
    localparam logic [FW-1:0] Z = '0;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [1:0]    in_valid;
    logic [2*FW-1:0] in_flit;
    logic [1:0]    in_ready, req, grant;
    logic          out_valid, out_ready, locked, owner, err;
    logic [FW-1:0] out_flit;
    logic [15:0]   pkt_cnt;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst;
        logic [1:0]    v;
        logic [FW-1:0] f0, f1;
        logic [1:0]    g;
        logic          o;
        logic [1:0]    rdy, req;
        logic          ov;
        logic [FW-1:0] of;
        logic          lk, ow;
        logic [15:0]   cnt;
        logic          er;
    } vec_t;

    vec_t tbl[27];

    wormhole_output_ctrl #(.FLIT_W(FW), .CNT_W(16)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_valid_i  (in_valid),
        .in_flit_i   (in_flit),
        .in_ready_o  (in_ready),
        .req_o       (req),
        .grant_i     (grant),
        .out_valid_o (out_valid),
        .out_flit_o  (out_flit),
        .out_ready_i (out_ready),
        .locked_o    (locked),
        .owner_o     (owner),
        .pkt_cnt_o   (pkt_cnt),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic vec_t vv(input logic r, input logic [1:0] v, input logic [FW-1:0] f0,
                                input logic [FW-1:0] f1, input logic [1:0] g, input logic o,
                                input logic [1:0] rdy, input logic [1:0] rq, input logic ov,
                                input logic [FW-1:0] of, input logic lk, input logic ow,
                                input logic [15:0] cnt, input logic er);
        vec_t x;
        x.rst = r; x.v = v; x.f0 = f0; x.f1 = f1; x.g = g; x.o = o;
        x.rdy = rdy; x.req = rq; x.ov = ov; x.of = of; x.lk = lk; x.ow = ow;
        x.cnt = cnt; x.er = er;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, act, exp);
        end
    endtask

    task automatic do_reset(input int idx);
        in_valid = 2'b00;
        grant    = 2'b00;
        arst_n   = 1'b0;
        #1;
        chk("rst_out_valid", idx, 64'(out_valid), 64'(0));
        chk("rst_out_flit", idx, 64'(out_flit), 64'(0));
        chk("rst_locked", idx, 64'(locked), 64'(0));
        chk("rst_pkt_cnt", idx, 64'(pkt_cnt), 64'(0));
        chk("rst_err", idx, 64'(err), 64'(0));
        #1;
        arst_n = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t x);
        @(negedge clk);
        if (x.rst) do_reset(idx);
        in_valid  = x.v;
        in_flit   = {x.f1, x.f0};
        grant     = x.g;
        out_ready = x.o;
        #1;
        chk("in_ready", idx, 64'(in_ready), 64'(x.rdy));
        chk("req", idx, 64'(req), 64'(x.req));
        @(posedge clk);
        #1;
        chk("out_valid", idx, 64'(out_valid), 64'(x.ov));
        if (x.ov) chk("out_flit", idx, 64'(out_flit), 64'(x.of));
        chk("locked", idx, 64'(locked), 64'(x.lk));
        if (x.lk) chk("owner", idx, 64'(owner), 64'(x.ow));
        chk("pkt_cnt", idx, 64'(pkt_cnt), 64'(x.cnt));
        chk("err", idx, 64'(err), 64'(x.er));
        n_vec++;
    endtask

    initial begin
        //            r     v      f0                f1                g      o     rdy    req    ov    of                 lk    ow    cnt    er
        tbl[0]  = vv(1'b0, 2'b01, mk(TH, 32'h1),    Z,                2'b01, 1'b1, 2'b01, 2'b01, 1'b1, mk(TH, 32'h1),    1'b1, 1'b0, 16'd0, 1'b0);
        tbl[1]  = vv(1'b0, 2'b01, mk(TB_, 32'h2),   Z,                2'b01, 1'b1, 2'b01, 2'b00, 1'b1, mk(TB_, 32'h2),   1'b1, 1'b0, 16'd0, 1'b0);
        tbl[2]  = vv(1'b0, 2'b01, mk(TT, 32'h3),    Z,                2'b01, 1'b1, 2'b01, 2'b00, 1'b1, mk(TT, 32'h3),    1'b0, 1'b0, 16'd1, 1'b0);
        tbl[3]  = vv(1'b0, 2'b00, Z,                Z,                2'b00, 1'b1, 2'b00, 2'b00, 1'b0, Z,                1'b0, 1'b0, 16'd1, 1'b0);
        tbl[4]  = vv(1'b0, 2'b11, mk(TH, 32'h10),   mk(TH, 32'h20),   2'b01, 1'b1, 2'b01, 2'b11, 1'b1, mk(TH, 32'h10),   1'b1, 1'b0, 16'd1, 1'b0);
        tbl[5]  = vv(1'b0, 2'b11, mk(TB_, 32'h11),  mk(TH, 32'h20),   2'b01, 1'b1, 2'b01, 2'b00, 1'b1, mk(TB_, 32'h11),  1'b1, 1'b0, 16'd1, 1'b0);
        tbl[6]  = vv(1'b0, 2'b11, mk(TT, 32'h12),   mk(TH, 32'h20),   2'b00, 1'b1, 2'b01, 2'b00, 1'b1, mk(TT, 32'h12),   1'b0, 1'b0, 16'd2, 1'b0);
        tbl[7]  = vv(1'b0, 2'b10, Z,                mk(TH, 32'h20),   2'b10, 1'b1, 2'b10, 2'b10, 1'b1, mk(TH, 32'h20),   1'b1, 1'b1, 16'd2, 1'b0);
        tbl[8]  = vv(1'b0, 2'b10, Z,                mk(TB_, 32'h21),  2'b00, 1'b1, 2'b10, 2'b00, 1'b1, mk(TB_, 32'h21),  1'b1, 1'b1, 16'd2, 1'b0);
        tbl[9]  = vv(1'b0, 2'b10, Z,                mk(TT, 32'h22),   2'b00, 1'b0, 2'b00, 2'b00, 1'b1, mk(TB_, 32'h21),  1'b1, 1'b1, 16'd2, 1'b0);
        tbl[10] = vv(1'b0, 2'b10, Z,                mk(TT, 32'h22),   2'b00, 1'b0, 2'b00, 2'b00, 1'b1, mk(TB_, 32'h21),  1'b1, 1'b1, 16'd2, 1'b0);
        tbl[11] = vv(1'b0, 2'b10, Z,                mk(TT, 32'h22),   2'b00, 1'b0, 2'b00, 2'b00, 1'b1, mk(TB_, 32'h21),  1'b1, 1'b1, 16'd2, 1'b0);
        tbl[12] = vv(1'b0, 2'b10, Z,                mk(TT, 32'h22),   2'b00, 1'b1, 2'b10, 2'b00, 1'b1, mk(TT, 32'h22),   1'b0, 1'b0, 16'd3, 1'b0);
        tbl[13] = vv(1'b0, 2'b00, Z,                Z,                2'b00, 1'b1, 2'b00, 2'b00, 1'b0, Z,                1'b0, 1'b0, 16'd3, 1'b0);
        tbl[14] = vv(1'b0, 2'b10, Z,                mk(THT, 32'h30),  2'b10, 1'b1, 2'b10, 2'b10, 1'b1, mk(THT, 32'h30),  1'b0, 1'b0, 16'd4, 1'b0);
        tbl[15] = vv(1'b0, 2'b00, Z,                Z,                2'b00, 1'b1, 2'b00, 2'b00, 1'b0, Z,                1'b0, 1'b0, 16'd4, 1'b0);
        tbl[16] = vv(1'b0, 2'b01, mk(TB_, 32'h40),  Z,                2'b00, 1'b1, 2'b00, 2'b00, 1'b0, Z,                1'b0, 1'b0, 16'd4, 1'b0);
        tbl[17] = vv(1'b0, 2'b01, mk(THT, 32'h50),  Z,                2'b01, 1'b1, 2'b01, 2'b01, 1'b1, mk(THT, 32'h50),  1'b0, 1'b0, 16'd5, 1'b0);
        tbl[18] = vv(1'b0, 2'b10, Z,                mk(TH, 32'h60),   2'b10, 1'b0, 2'b00, 2'b10, 1'b1, mk(THT, 32'h50),  1'b0, 1'b0, 16'd5, 1'b0);
        tbl[19] = vv(1'b0, 2'b10, Z,                mk(TH, 32'h60),   2'b10, 1'b1, 2'b10, 2'b10, 1'b1, mk(TH, 32'h60),   1'b1, 1'b1, 16'd5, 1'b0);
        tbl[20] = vv(1'b0, 2'b10, Z,                mk(TT, 32'h62),   2'b00, 1'b1, 2'b10, 2'b00, 1'b1, mk(TT, 32'h62),   1'b0, 1'b0, 16'd6, 1'b0);
        tbl[21] = vv(1'b0, 2'b11, mk(TH, 32'h70),   mk(TH, 32'h71),   2'b11, 1'b1, 2'b00, 2'b11, 1'b0, Z,                1'b0, 1'b0, 16'd6, 1'b1);
        tbl[22] = vv(1'b1, 2'b01, mk(TH, 32'h80),   Z,                2'b10, 1'b1, 2'b00, 2'b01, 1'b0, Z,                1'b0, 1'b0, 16'd0, 1'b1);
        tbl[23] = vv(1'b1, 2'b01, mk(TH, 32'h90),   Z,                2'b01, 1'b1, 2'b01, 2'b01, 1'b1, mk(TH, 32'h90),   1'b1, 1'b0, 16'd0, 1'b0);
        tbl[24] = vv(1'b0, 2'b01, mk(THT, 32'h91),  Z,                2'b01, 1'b1, 2'b01, 2'b00, 1'b1, mk(THT, 32'h91),  1'b1, 1'b0, 16'd0, 1'b1);
        tbl[25] = vv(1'b0, 2'b01, mk(TT, 32'h92),   Z,                2'b00, 1'b1, 2'b01, 2'b00, 1'b1, mk(TT, 32'h92),   1'b0, 1'b0, 16'd1, 1'b1);
        tbl[26] = vv(1'b0, 2'b00, Z,                Z,                2'b00, 1'b1, 2'b00, 2'b00, 1'b0, Z,                1'b0, 1'b0, 16'd1, 1'b1);

        arst_n    = 1'b0;
        in_valid  = 2'b00;
        in_flit   = '0;
        grant     = 2'b00;
        out_ready = 1'b0;
        #2;
        chk("init_out_valid", -1, 64'(out_valid), 64'(0));
        chk("init_out_flit", -1, 64'(out_flit), 64'(0));
        chk("init_locked", -1, 64'(locked), 64'(0));
        chk("init_pkt_cnt", -1, 64'(pkt_cnt), 64'(0));
        chk("init_err", -1, 64'(err), 64'(0));
        chk("init_req", -1, 64'(req), 64'(0));
        #1;
        arst_n = 1'b1;

        for (int i = 0; i < 27; i++) apply(i, tbl[i]);

        // Reset asserted mid-packet, right after ch0's BODY is accepted.
        apply(100, vv(1'b1, 2'b01, mk(TH, 32'ha0), Z, 2'b01, 1'b1, 2'b01, 2'b01, 1'b1, mk(TH, 32'ha0), 1'b1, 1'b0, 16'd0, 1'b0));
        apply(101, vv(1'b0, 2'b01, mk(TB_, 32'ha1), Z, 2'b00, 1'b1, 2'b01, 2'b00, 1'b1, mk(TB_, 32'ha1), 1'b1, 1'b0, 16'd0, 1'b0));
        in_valid = 2'b00;
        arst_n   = 1'b0;
        #1;
        chk("midrst_locked", 102, 64'(locked), 64'(0));
        chk("midrst_out_valid", 102, 64'(out_valid), 64'(0));
        chk("midrst_pkt_cnt", 102, 64'(pkt_cnt), 64'(0));
        #1;
        arst_n = 1'b1;
        apply(103, vv(1'b0, 2'b10, Z, mk(TH, 32'hb0), 2'b10, 1'b1, 2'b10, 2'b10, 1'b1, mk(TH, 32'hb0), 1'b1, 1'b1, 16'd0, 1'b0));
        apply(104, vv(1'b0, 2'b10, Z, mk(TT, 32'hb1), 2'b00, 1'b1, 2'b10, 2'b00, 1'b1, mk(TT, 32'hb1), 1'b0, 1'b0, 16'd1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/wormhole_output_ctrl.md
Name: wormhole_output_ctrl

Overview:
Output-port controller in the router, directly downstream of high_prior_arbiter. It drives the arbiter's 2-bit request vector from head flits waiting on two input channels and consumes the returned grant. It locks the output to the winning channel for a whole wormhole packet, head through tail. Accepted flits pass through a one-entry output register with valid/ready handshake toward the link.

Parameters:
FLIT_W, 34, total flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type
CNT_W, 16, width of the completed-packet counter

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
in_valid_i  input  2  per-channel flit valid
in_flit_i  input  2*FLIT_W  channel k flit at [k*FLIT_W +: FLIT_W]
in_ready_o  output  2  per-channel accept; a flit transfers when valid&ready
req_o  output  2  request vector to high_prior_arbiter
grant_i  input  2  grant from arbiter, combinational on req_o, same cycle
out_valid_o  output  1  output register holds a flit
out_flit_o  output  FLIT_W  registered flit
out_ready_i  input  1  link accepts flit
locked_o  output  1  packet in progress
owner_o  output  1  locked channel index; meaningful only when locked_o=1
pkt_cnt_o  output  CNT_W  count of completed packets
err_o  output  1  sticky protocol/grant error

Behaviour:
- Flit types: HEAD=2'b01, BODY=2'b00, TAIL=2'b10, HEAD_TAIL=2'b11.
- can_acc = !out_valid_o || out_ready_i. The output register loads on any accepted flit and clears when out_ready_i=1 with no new load.
- Latency: an accepted flit appears on out_flit_o the next cycle. Back-to-back flow gives full throughput.
- FSM IDLE:
  - req_o[k] = in_valid_i[k] && type[k] is HEAD or HEAD_TAIL.
  - If grant_i is one-hot, the granted channel's req_o bit is 1, and can_acc=1: set in_ready_o[g]=1 and transfer.
  - On a HEAD transfer: go to LOCK with owner=g.
  - On a HEAD_TAIL transfer: stay IDLE and increment pkt_cnt_o.
  - Otherwise in_ready_o=0.
- FSM LOCK:
  - req_o=2'b00; grant_i is ignored.
  - in_ready_o[owner]=can_acc; in_ready_o of the other channel is 0.
  - On a TAIL transfer: go to IDLE and increment pkt_cnt_o.
  - A HEAD or HEAD_TAIL flit on the owner while locked is forwarded as-is, sets err_o, and the lock is kept.
- Error conditions in IDLE:
  - grant_i=2'b11: no transfer, err_o set.
  - A grant bit set on a channel whose req_o bit is 0: no transfer, err_o set.
  - BODY/TAIL flits in IDLE are never requested. They stall (ready=0) with no error.
- Simultaneous events: release on TAIL and a new head on the same cycle are not possible. The next head is arbitrated one cycle after the tail is accepted, so the IDLE cycle is mandatory.
- Output-register stall: with out_valid_o=1 and out_ready_i=0, out_flit_o holds stable and all in_ready_o=0. In IDLE, req_o still reflects waiting heads.
- pkt_cnt_o wraps modulo 2^CNT_W. err_o clears only on reset.
- Reset values, asynchronous and effective immediately including mid-packet:
  - FSM=IDLE, owner=0, out_valid_o=0, out_flit_o=0, pkt_cnt_o=0, err_o=0, locked_o=0.
  - Partial packets are dropped.

Decomposition:
- Package noc_pkg holds:
  - the flit_type_t enum (HEAD/BODY/TAIL/HEAD_TAIL encodings)
  - the FLIT_W default
  - the type-field slice constants
  - the FSM state encoding
- One sub-module: noc_out_reg, the one-entry valid/ready register with can_acc output. The FSM, mux and counter stay in the top level.

Test Plan:
- ch0 sends HEAD, BODY, TAIL (flit data 0x1,0x2,0x3) with grant_i=2'b01 and out_ready_i=1 -> out_flit_o shows 0x1,0x2,0x3 on cycles 1-3; locked_o high from cycle 1 to cycle 3; pkt_cnt_o=1.
- Both channels present HEAD, arbiter returns 2'b01 -> ch0's packet is forwarded fully, in_ready_o[1]=0 throughout the lock. req_o=2'b10 appears one cycle after ch0's TAIL, then ch1's packet is forwarded.
- ch1 sends HEAD_TAIL with grant_i=2'b10 -> single flit forwarded; locked_o never rises; pkt_cnt_o increments by 1.
- out_ready_i held 0 for 3 cycles mid-packet -> out_flit_o stable, in_ready_o=2'b00. The flow resumes with no loss or duplication.
- grant_i forced to 2'b11 in IDLE -> no transfer and err_o=1. After a further arst_n pulse -> err_o=0.
- arst_n asserted after ch0's BODY while locked -> locked_o=0, out_valid_o=0 immediately. A new HEAD on ch1 is then arbitrated normally.
